// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The header byte helper is used only when UART_ARB_ID_HEADER_EN is defined.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      STREAM = 2'd2
   } arb_state_e;

   // Grant id width carried into the header byte; covers up to 8 requesters.
   localparam int ARB_ID_W = 3;

   localparam int HDR_MAX_W = 32;

   function automatic logic [HDR_MAX_W-1:0] hdr_byte(
      input int unsigned         width,
      input logic [ARB_ID_W-1:0] id
   );
      logic [HDR_MAX_W-1:0] b;
      b = HDR_MAX_W'(id);
      b[width-1] = 1'b1;
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin priority encoder: first set request strictly after rr_ptr,
// wrapping around, so the previous winner has the lowest priority.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   win_idx,
   output logic               found
);

   int slot;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      slot    = 0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         slot = (int'(rr_ptr) + off) % NUM_REQ;
         if (req[slot]) begin
            found   = 1'b1;
            win_idx = IDX_W'(slot);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter.
// Define UART_ARB_ID_HEADER_EN to prefix each packet with a grant-id byte.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ena,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         uart_tx_data,
   output logic                          uart_tx_valid,
   input  logic                          uart_tx_ready,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          overrun_err
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_PKT_LEN + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
   end
   if (MAX_PKT_LEN < 2) begin : g_bad_max_len
      $error("uart_tx_arbiter: MAX_PKT_LEN must be at least 2");
   end

   arb_state_e state_q, state_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [BW-1:0] beat_q, beat_d;
   logic ovr_q, ovr_d;

   logic [GW-1:0] win_idx;
   logic win_found;
   logic sel_valid;
   logic sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic fire;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (GW)
   ) u_picker (
      .req     (req_valid),
      .rr_ptr  (rr_ptr_q),
      .win_idx (win_idx),
      .found   (win_found)
   );

   assign sel_valid = req_valid[grant_q];
   assign sel_last  = req_last[grant_q];
   assign sel_data  = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef UART_ARB_ID_HEADER_EN
   logic [DATA_WIDTH-1:0] hdr_data;

   assign hdr_data = DATA_WIDTH'(
      hdr_byte(DATA_WIDTH, ARB_ID_W'(grant_q)));
`endif

   // The handshake path is combinational so a byte moves in the same cycle.
   always_comb begin
      uart_tx_valid = 1'b0;
      uart_tx_data  = '0;
      req_ready     = '0;
      case (state_q)
         STREAM: begin
            uart_tx_valid      = ena && sel_valid;
            uart_tx_data       = sel_data;
            req_ready[grant_q] = ena && uart_tx_ready;
         end
`ifdef UART_ARB_ID_HEADER_EN
         HEADER: begin
            uart_tx_valid = ena;
            uart_tx_data  = hdr_data;
         end
`endif
         default: ;
      endcase
   end

   assign fire = uart_tx_valid && uart_tx_ready;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      beat_d   = beat_q;
      ovr_d    = 1'b0;
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  grant_d = win_idx;
                  beat_d  = '0;
`ifdef UART_ARB_ID_HEADER_EN
                  state_d = HEADER;
`else
                  state_d = STREAM;
`endif
               end
            end
`ifdef UART_ARB_ID_HEADER_EN
            HEADER: begin
               if (fire) begin
                  state_d = STREAM;
               end
            end
`endif
            STREAM: begin
               if (fire) begin
                  beat_d = beat_q + 1'b1;
                  if (sel_last) begin
                     state_d  = IDLE;
                     rr_ptr_d = grant_q;
                  end else if (beat_q == BW'(MAX_PKT_LEN - 1)) begin
                     // Forced release: the grantee goes to the back of the queue.
                     ovr_d    = 1'b1;
                     state_d  = IDLE;
                     rr_ptr_d = grant_q;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= GW'(NUM_REQ - 1);
         grant_q  <= '0;
         beat_q   <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         beat_q   <= beat_d;
         ovr_q    <= ovr_d;
      end
   end

   assign grant_id    = grant_q;
   assign busy        = (state_q != IDLE);
   assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit, 16 max).
// Builds with or without UART_ARB_ID_HEADER_EN.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        ena;
   logic [31:0] req_data;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [1:0]  grant_id;
   logic        busy;
   logic        overrun_err;

   uart_tx_arbiter #(
      .NUM_REQ     (4),
      .DATA_WIDTH  (8),
      .MAX_PKT_LEN (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ena           (ena),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .grant_id      (grant_id),
      .busy          (busy),
      .overrun_err   (overrun_err)
   );

   // Source queues: bit 8 is the last flag, bits 7:0 the byte.
   logic [8:0] srcq [4][$];
   logic [7:0] got [$];
   logic [1:0] gid [$];
   int         xcyc [$];
   logic [7:0] hdr_log [$];

   int   cyc;
   int   viol;
   int   ovr_n;
   int   ovr_cyc;
   int   rdy_mode;
   int   hdr_total;
   logic last_xfer_busy;
   int   checks;
   int   errors;

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[i*8 +: 8] = srcq[i][0][7:0];
            req_last[i]        = srcq[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*8 +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      uart_tx_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 4 == 3);
   endtask

   // One clock: observe at negedge, update sources just after posedge.
   task automatic step();
      logic [3:0] acc;
      acc = 4'b0;
      @(negedge clk);
      cyc++;
      if (!reset) begin
         if (uart_tx_valid && uart_tx_ready) begin
            if (req_ready == 4'b0) begin
               hdr_log.push_back(uart_tx_data);
               hdr_total++;
            end else begin
               got.push_back(uart_tx_data);
               gid.push_back(grant_id);
               xcyc.push_back(cyc);
               last_xfer_busy = busy;
            end
         end
         acc = req_valid & req_ready;
         for (int i = 0; i < 4; i++) begin
            if (req_ready[i] && !(busy && grant_id == 2'(i))) viol++;
         end
         if (overrun_err) begin
            ovr_n++;
            ovr_cyc = cyc;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc[i]) void'(srcq[i].pop_front());
      end
      drive();
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         step();
         k++;
      end
      checks++;
      if (got.size() < n) begin
         errors++;
         $display("FAIL wait_bytes: got %0d bytes, required %0d", got.size(), n);
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) srcq[i].delete();
      got.delete();
      gid.delete();
      xcyc.delete();
      hdr_log.delete();
      viol     = 0;
      ovr_n    = 0;
      ovr_cyc  = -1;
      rdy_mode = 0;
      ena      = 1'b1;
      reset    = 1'b1;
      drive();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) srcq[i].delete();
      srcq[2].push_back({1'b1, 8'hEE});
      reset = 1'b1;
      ena   = 1'b1;
      drive();
      step();
      step();
      checks += 6;
      if (uart_tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b, required 0", uart_tx_valid);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      if (grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_grant: got %0d, required 0", grant_id);
      end
      if (overrun_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovr: got %b, required 0", overrun_err);
      end
      if (req_ready !== 4'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b, required 0000", req_ready);
      end
      if (uart_tx_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h, required 00", uart_tx_data);
      end
      srcq[2].delete();
      reset = 1'b0;
   endtask

   task automatic test_single();
      logic [7:0] exp [3];
      exp[0] = 8'h11;
      exp[1] = 8'h22;
      exp[2] = 8'h33;
      do_reset();
      rdy_mode = 1;
      srcq[0].push_back({1'b0, 8'h11});
      srcq[0].push_back({1'b0, 8'h22});
      srcq[0].push_back({1'b1, 8'h33});
      drive();
      wait_bytes(3, 200);
      checks += 2;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_fall: got %b, required 0", busy);
      end
      if (last_xfer_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_xfer: got %b, required 1", last_xfer_busy);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got.size() <= k || got[k] !== exp[k] || gid[k] !== 2'd0) begin
            errors++;
            $display("FAIL single_byte%0d: got %h, required %h from 0", k,
                     (got.size() > k) ? got[k] : 8'hxx, exp[k]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] e;
      logic [1:0] eg;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         srcq[i].push_back({1'b0, 4'(i), 4'h1});
         srcq[i].push_back({1'b1, 4'(i), 4'h2});
      end
      drive();
      wait_bytes(8, 100);
      for (int k = 0; k < 8; k++) begin
         e  = {4'(k / 2), 4'(k % 2 + 1)};
         eg = 2'(k / 2);
         checks++;
         if (got.size() <= k || got[k] !== e || gid[k] !== eg) begin
            errors++;
            $display("FAIL rr_byte%0d: got %h, required %h from %0d", k,
                     (got.size() > k) ? got[k] : 8'hxx, e, eg);
         end
      end
      checks++;
      if (viol !== 0) begin
         errors++;
         $display("FAIL rr_ready_excl: got %0d stray ready cycles, required 0", viol);
      end
   endtask

   task automatic test_overrun();
      int n1;
      do_reset();
      for (int b = 0; b < 20; b++) srcq[1].push_back({1'b0, 8'(8'h40 + b)});
      srcq[2].push_back({1'b1, 8'hC3});
      drive();
      wait_bytes(21, 100);
      n1 = 0;
      while (n1 < gid.size() && gid[n1] == 2'd1) n1++;
      checks++;
      if (n1 !== 16) begin
         errors++;
         $display("FAIL ovr_run_len: got %0d, required 16", n1);
      end
      checks++;
      if (got.size() < 21 || got[15] !== 8'h4F || got[16] !== 8'hC3 ||
          gid[16] !== 2'd2) begin
         errors++;
         $display("FAIL ovr_next_grant: got byte16 %h, required c3 from 2",
                  (got.size() > 16) ? got[16] : 8'hxx);
      end
      checks++;
      if (got.size() < 21 || got[17] !== 8'h50 || got[20] !== 8'h53) begin
         errors++;
         $display("FAIL ovr_resume: got %h..%h, required 50..53",
                  (got.size() > 17) ? got[17] : 8'hxx,
                  (got.size() > 20) ? got[20] : 8'hxx);
      end
      checks++;
      if (ovr_n !== 1) begin
         errors++;
         $display("FAIL ovr_count: got %0d, required 1", ovr_n);
      end
      checks++;
      if (xcyc.size() < 16 || ovr_cyc !== xcyc[15] + 1) begin
         errors++;
         $display("FAIL ovr_timing: got cycle %0d, required %0d", ovr_cyc,
                  (xcyc.size() > 15) ? xcyc[15] + 1 : -1);
      end
      // Requester 1 now idles with the grant; requester 0 must keep waiting.
      srcq[0].push_back({1'b1, 8'h0E});
      drive();
      for (int k = 0; k < 8; k++) step();
      checks++;
      if (got.size() !== 21 || busy !== 1'b1 || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL ovr_hold_grant: got %0d bytes grant %0d busy %b, required 21 grant 1 busy 1",
                  got.size(), grant_id, busy);
      end
   endtask

   task automatic test_ena();
      int bad;
      do_reset();
      for (int b = 0; b < 6; b++) srcq[3].push_back({b == 5, 8'(8'h60 + b)});
      drive();
      wait_bytes(2, 50);
      ena = 1'b0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (uart_tx_valid || req_ready != 4'b0) bad++;
      end
      checks += 2;
      if (got.size() !== 2 || bad !== 0) begin
         errors++;
         $display("FAIL ena_freeze: got %0d bytes %0d active cycles, required 2 and 0",
                  got.size(), bad);
      end
      if (busy !== 1'b1 || grant_id !== 2'd3) begin
         errors++;
         $display("FAIL ena_hold: got busy %b grant %0d, required 1 and 3",
                  busy, grant_id);
      end
      ena = 1'b1;
      wait_bytes(6, 50);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (got.size() <= k || got[k] !== 8'(8'h60 + k)) begin
            errors++;
            $display("FAIL ena_byte%0d: got %h, required %h", k,
                     (got.size() > k) ? got[k] : 8'hxx, 8'(8'h60 + k));
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      srcq[1].push_back({1'b0, 8'h71});
      srcq[1].push_back({1'b0, 8'h72});
      srcq[1].push_back({1'b0, 8'h73});
      srcq[1].push_back({1'b1, 8'h74});
      drive();
      wait_bytes(1, 50);
      reset = 1'b1;
      step();
      checks += 2;
      if (uart_tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_valid: got %b, required 0", uart_tx_valid);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rmid_busy: got %b, required 0", busy);
      end
      reset = 1'b0;
      srcq[0].push_back({1'b1, 8'h0E});
      drive();
      wait_bytes(2, 50);
      checks++;
      if (got.size() < 2 || got[1] !== 8'h0E || gid[1] !== 2'd0) begin
         errors++;
         $display("FAIL rmid_next_grant: got %h from %0d, required 0e from 0",
                  (got.size() > 1) ? got[1] : 8'hxx,
                  (gid.size() > 1) ? gid[1] : 2'bxx);
      end
   endtask

`ifdef UART_ARB_ID_HEADER_EN
   task automatic test_header();
      do_reset();
      srcq[2].push_back({1'b1, 8'h5A});
      drive();
      wait_bytes(1, 50);
      checks += 2;
      if (hdr_log.size() !== 1 || hdr_log[0] !== 8'h82) begin
         errors++;
         $display("FAIL hdr_byte: got %h, required 82",
                  (hdr_log.size() > 0) ? hdr_log[0] : 8'hxx);
      end
      if (got.size() < 1 || got[0] !== 8'h5A || gid[0] !== 2'd2) begin
         errors++;
         $display("FAIL hdr_payload: got %h, required 5a from 2",
                  (got.size() > 0) ? got[0] : 8'hxx);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks        = 0;
      errors        = 0;
      cyc           = 0;
      viol          = 0;
      ovr_n         = 0;
      ovr_cyc       = -1;
      rdy_mode      = 0;
      hdr_total     = 0;
      last_xfer_busy = 1'b0;
      reset         = 1'b1;
      ena           = 1'b1;
      req_data      = '0;
      req_valid     = '0;
      req_last      = '0;
      uart_tx_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_overrun();
      test_ena();
      test_reset_mid();
`ifdef UART_ARB_ID_HEADER_EN
      test_header();
`else
      checks++;
      if (hdr_total !== 0) begin
         errors++;
         $display("FAIL no_header: got %0d header beats, required 0", hdr_total);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ independent byte-stream requesters. Grants are round-robin and packet-atomic: a granted requester keeps the transmitter until its last byte is accepted. Sits between on-chip sources (status, loopback, debug) and the uart tx_data/tx_valid/tx_ready interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; matches the uart DATA_WIDTH
MAX_PKT_LEN, 16, maximum bytes per grant before a forced release (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ena  in  1  global enable; low freezes all state, with no handshakes
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
req_valid  in  NUM_REQ  byte valid per requester
req_last  in  NUM_REQ  final byte of packet, qualified by req_valid
req_ready  out  NUM_REQ  byte accepted when req_valid[i] && req_ready[i]
uart_tx_data  out  DATA_WIDTH  to uart tx_data
uart_tx_valid  out  1  to uart tx_valid
uart_tx_ready  in  1  from uart tx_ready
grant_id  out  $clog2(NUM_REQ)  current or most recent grantee
busy  out  1  high in any state other than IDLE
overrun_err  out  1  one-cycle pulse on a forced release

Behaviour:
- Transfer happens on a cycle where uart_tx_valid && uart_tx_ready are both high.
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), grant_id=0, beat_cnt=0, all outputs 0.
- IDLE: if ena and any req_valid, pick the first set bit scanning rr_ptr+1 upward with wrap. Register grant_id, set beat_cnt=0, go to STREAM (or HEADER if the option is enabled). Arbitration takes 1 cycle; no output handshake occurs in IDLE.
- STREAM: uart_tx_valid = ena && req_valid[g]; uart_tx_data = req_data[g]; req_ready[g] = ena && uart_tx_ready. All other req_ready bits are 0. These paths are combinational, with zero added latency.
- On each transfer beat_cnt increments.
  - If req_last[g], go to IDLE and set rr_ptr=g.
  - Else if beat_cnt==MAX_PKT_LEN-1, pulse overrun_err, go to IDLE, and set rr_ptr=g.
- A grantee dropping req_valid mid-packet keeps the grant indefinitely. There is no timeout.
- Requests arriving while the arbiter is busy wait. A requester that just finished cannot win again while others are requesting.
- ena low: state, counters and pointer hold; uart_tx_valid=0; req_ready=0.
- Reset mid-packet: abort immediately. uart_tx_valid=0 from the next cycle; the partial packet is lost.
- beat_cnt width is $clog2(MAX_PKT_LEN+1) and never wraps.

Optional Feature:
Macro UART_ARB_ID_HEADER_EN.
- Defined: after arbitration the block enters HEADER. It drives uart_tx_valid=ena and uart_tx_data = {1'b1, zeros, grant_id}, with req_ready all 0. On transfer it goes to STREAM. The header does not count toward MAX_PKT_LEN.
- Undefined: IDLE goes straight to STREAM and HEADER logic is absent.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum {IDLE, HEADER, STREAM};
  - the header-byte function;
  - a localparam for the grant id width.
- Sub-module rr_picker: combinational round-robin priority encoder. Inputs are the request vector and rr_ptr; outputs are the winner index and a found flag.

Test Plan:
- Reset release, req_valid=4'b0001, 3-byte packet 0x11,0x22,0x33 (last on 0x33), uart_tx_ready toggling 1-of-4 cycles -> uart sees 11,22,33 in order; busy falls the cycle after the 0x33 transfer.
- All four requesters each present a 2-byte packet at once -> grant order 0,1,2,3. Packets are not interleaved, and each req_ready is high only during that requester's grant.
- Requester 1 sends 20 bytes with no last, MAX_PKT_LEN=16 -> 16 transfers, overrun_err pulses once on the 16th, and requester 2 (pending) is granted next.
- ena driven low for 10 cycles mid-packet -> no transfers, state held; the stream resumes byte-exact afterwards.
- reset asserted on byte 2 of a 4-byte packet -> uart_tx_valid=0 next cycle, busy=0, and the next grant goes to requester 0.
- With UART_ARB_ID_HEADER_EN, requester 2 sends 0x5A (last) -> uart sees 0x82 then 0x5A.
